// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the issue/scoreboard side and the
// register file write port of regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_a_valid;
  logic [4:0]      i_a_rd;
  logic [XLEN-1:0] i_a_data;
  logic            o_a_ready;
  logic            i_b_valid;
  logic [4:0]      i_b_rd;
  logic [XLEN-1:0] i_b_data;
  logic            o_b_ready;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd;
  logic [31:0]     o_busy;
  logic            o_readwrite;
  logic [4:0]      o_writereg;
  logic [XLEN-1:0] o_writedata;
  logic            o_err;

  modport slave (
    input  i_a_valid, i_a_rd, i_a_data,
    input  i_b_valid, i_b_rd, i_b_data,
    input  i_issue_valid, i_issue_rd,
    output o_a_ready, o_b_ready, o_busy,
    output o_readwrite, o_writereg, o_writedata, o_err
  );

  modport master (
    output i_a_valid, i_a_rd, i_a_data,
    output i_b_valid, i_b_rd, i_b_data,
    output i_issue_valid, i_issue_rd,
    input  o_a_ready, o_b_ready, o_busy,
    input  o_readwrite, o_writereg, o_writedata, o_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with a pending-destination scoreboard.
// Optional macro WB_OUTPUT_REG_EN registers the register-file write outputs.
`ifndef REG_WRITE_EN
`define REG_WRITE_EN 1'b1
`endif

module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic       WE_ON      = `REG_WRITE_EN;
  localparam logic       WE_OFF     = ~WE_ON;

  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     busy_q, busy_d;
  logic            err_q, err_d;
  logic            grant_a_s, grant_b_s;
  logic [4:0]      com_rd_s;
  logic [XLEN-1:0] com_data_s;
  logic            com_we_s;
  logic [31:0]     set_vec_s, clr_vec_s, busy_live_s;
  logic            err_waw_s, err_unowed_s, err_aover_s;

  // Arbitration: B wins a contested cycle only once it has waited MAX_WAIT times
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({bus.i_a_valid, bus.i_b_valid})
      2'b10: grant_a_s = 1'b1;
      2'b01: grant_b_s = 1'b1;
      2'b11: begin
        if (wait_cnt_q < MAX_WAIT_C) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Starvation counter: counts contested cycles lost by B
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.i_b_valid || grant_b_s) begin
      wait_cnt_d = 4'd0;
    end else if (grant_a_s && (wait_cnt_q < MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Selected write; x0 is granted but never enables the register file
  always_comb begin
    com_rd_s   = 5'd0;
    com_data_s = '0;
    if (grant_b_s) begin
      com_rd_s   = bus.i_b_rd;
      com_data_s = bus.i_b_data;
    end else if (grant_a_s) begin
      com_rd_s   = bus.i_a_rd;
      com_data_s = bus.i_a_data;
    end else begin
      com_rd_s   = 5'd0;
      com_data_s = '0;
    end
    com_we_s = (grant_a_s || grant_b_s) && (com_rd_s != 5'd0);
  end

  assign bus.o_a_ready = i_reset_n & grant_a_s;
  assign bus.o_b_ready = i_reset_n & grant_b_s;

`ifdef WB_OUTPUT_REG_EN
  logic            wr_en_q;
  logic [4:0]      wr_rd_q;
  logic [XLEN-1:0] wr_data_q;
  logic            wb_b_q;

  // Output stage: write is presented one cycle after the handshake
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= 5'd0;
      wr_data_q <= '0;
      wb_b_q    <= 1'b0;
    end else begin
      wr_en_q   <= com_we_s;
      wr_rd_q   <= com_rd_s;
      wr_data_q <= com_data_s;
      wb_b_q    <= grant_b_s;
    end
  end

  assign bus.o_readwrite = wr_en_q ? WE_ON : WE_OFF;
  assign bus.o_writereg  = wr_rd_q;
  assign bus.o_writedata = wr_data_q;
  assign clr_vec_s = (wb_b_q && (wr_rd_q != 5'd0)) ? (32'd1 << wr_rd_q) : 32'd0;
`else
  assign bus.o_readwrite = (i_reset_n && com_we_s) ? WE_ON : WE_OFF;
  assign bus.o_writereg  = i_reset_n ? com_rd_s : 5'd0;
  assign bus.o_writedata = i_reset_n ? com_data_s : '0;
  assign clr_vec_s = (grant_b_s && (bus.i_b_rd != 5'd0)) ? (32'd1 << bus.i_b_rd) : 32'd0;
`endif

  assign set_vec_s   = (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) ?
                       (32'd1 << bus.i_issue_rd) : 32'd0;
  // A bit being cleared this cycle may be reissued without counting as WAW
  assign busy_live_s = busy_q & ~clr_vec_s;

  // Scoreboard update (set beats clear) and sticky protocol errors
  always_comb begin
    busy_d       = busy_live_s | set_vec_s;
    err_waw_s    = bus.i_issue_valid && (bus.i_issue_rd != 5'd0) && busy_live_s[bus.i_issue_rd];
    err_unowed_s = grant_b_s && (bus.i_b_rd != 5'd0) && !busy_q[bus.i_b_rd];
    err_aover_s  = grant_a_s && busy_q[bus.i_a_rd];
    err_d        = err_q | err_waw_s | err_unowed_s | err_aover_s;
  end

  // State registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt_q <= 4'd0;
      busy_q     <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_err  = err_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
- Requester A is the in-order pipeline WB stage. Requester B is the long-latency unit (mul/div, load miss).
- Keeps a 32-entry scoreboard of destination registers still owed by B, so decode can stall on RAW/WAW hazards.
- Sits between the WB/long-latency units and the register file write inputs (write-enable, write-register, write-data).

Parameters:
- MAX_WAIT, 4, number of consecutive cycles B may be held off before it gets priority over A (1..15).
- XLEN, 32, data width.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_a_valid  input  1  pipeline WB has a result.
- i_a_rd  input  5  pipeline WB destination.
- i_a_data  input  XLEN  pipeline WB result.
- o_a_ready  output  1  A write accepted this cycle.
- i_b_valid  input  1  long-latency unit has a result.
- i_b_rd  input  5  long-latency destination.
- i_b_data  input  XLEN  long-latency result.
- o_b_ready  output  1  B write accepted this cycle.
- i_issue_valid  input  1  a long-latency op is issued this cycle.
- i_issue_rd  input  5  destination of the issued op.
- o_busy  output  32  scoreboard; bit n=1 means xn has a pending B write.
- o_readwrite  output  1  register file write enable; drives `REG_WRITE_EN when committing, else the opposite level.
- o_writereg  output  5  register file write address.
- o_writedata  output  XLEN  register file write data.
- o_err  output  1  sticky protocol error flag.

Behaviour:
- Reset (async, i_reset_n=0) sets:
  - o_busy=0, o_err=0, wait counter=0.
  - o_a_ready=0, o_b_ready=0.
  - o_readwrite=not-enabled, o_writereg=0, o_writedata=0.
  - Any in-flight grant is dropped.
- A handshake completes on valid&ready.
- At most one of o_a_ready/o_b_ready is high per cycle.
- ready never depends on the other requester's ready, only on both valids and the wait counter.
- Arbitration:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid and wait_cnt<MAX_WAIT: grant A; wait_cnt increments, saturating at MAX_WAIT.
  - Both valid and wait_cnt==MAX_WAIT: grant B.
  - wait_cnt clears on any B grant, and on any cycle with i_b_valid=0.
- Commit (no output register):
  - o_readwrite, o_writereg and o_writedata reflect the granted request in the same cycle (combinational).
  - Write lands in the register file at the next rising edge.
- rd==0 handling:
  - A request with rd==0 is still granted (ready asserted).
  - o_readwrite is not asserted, and the scoreboard is unaffected.
- Scoreboard:
  - i_issue_valid with rd!=0 sets busy[rd] at the next edge.
  - A B commit clears busy[b_rd] at the edge of the handshake.
  - Same-cycle issue and B commit to the same rd: set wins, so busy stays 1.
  - issue rd==0 is ignored.
- Errors (o_err set, sticky until reset):
  - i_issue_valid to an rd whose busy bit is already 1 (WAW on a pending op).
  - B handshake with busy[i_b_rd]==0 and i_b_rd!=0 (unowed write).
  - A handshake with busy[i_a_rd]==1 (pipeline overwriting a pending register).
  - The offending write is still performed; the busy update follows the normal rules.
- Reset mid-operation: pending scoreboard bits are lost; the issuing side must flush.
- Requesters must hold valid/rd/data stable until ready; the bench checks this with assertions.

Optional Feature:
- Macro WB_OUTPUT_REG_EN.
- Defined:
  - o_readwrite, o_writereg and o_writedata are registered, so the write appears one cycle after the handshake.
  - busy clear occurs on the cycle the registered write is presented, so busy drops one cycle later than without the macro.
  - ready timing is unchanged.
- Undefined: combinational commit as described above.

Test Plan:
- Reset: i_reset_n=0 asynchronously mid-cycle with A valid -> all outputs 0 / not-enabled immediately, o_busy=0.
- A alone: a_valid, rd=5, data=0xDEADBEEF -> o_a_ready=1 same cycle, o_readwrite enabled, o_writereg=5, o_writedata=0xDEADBEEF.
- Starvation, MAX_WAIT=4: A and B valid continuously -> A granted 4 cycles, B granted cycle 5, then A again for 4 cycles.
- Scoreboard flow: issue rd=7 -> o_busy[7]=1 next cycle. B commit rd=7 -> bit clears after the edge. Issue rd=9 and B commit rd=9 in the same cycle (busy[9] preset) -> busy[9] stays 1, o_err=0.
- x0 and errors:
  - A rd=0 -> ready=1, no write enable.
  - Issue rd=3 twice -> o_err=1.
  - B commit to non-busy rd=12 -> o_err=1, write still performed.
- With WB_OUTPUT_REG_EN: B commit rd=4 -> o_writereg=4 one cycle after o_b_ready, busy[4] clears one cycle later than without the macro.
